// File: rtl/dm_pkg.sv
// Shared encodings and sizing for the data memory stage.
// DM_W/DM_H/DM_B must stay in step with the controller's DMop decode.
package dm_pkg;

    typedef enum logic [1:0] {
        DM_W   = 2'b00,
        DM_H   = 2'b01,
        DM_B   = 2'b10,
        DM_RSV = 2'b11
    } dm_op_e;

    localparam int unsigned DM_DEPTH_WORDS = 3072;
    localparam int unsigned DM_AW          = 12;
    localparam int unsigned DM_BYTES       = DM_DEPTH_WORDS * 4;

endpackage

// File: rtl/dm_lane.sv
// Byte-lane logic for one access: enables, store merge, load extract/extend,
// and alignment/reserved-op fault. Purely combinational.
module dm_lane
    import dm_pkg::*;
(
    input  logic [1:0]  i_addr_lo,
    input  logic [1:0]  i_dm_op,
    input  logic [31:0] i_wd,
    input  logic [31:0] i_old,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_rdata,
    output logic        o_fault
);

    logic [31:0] w_src;
    logic [15:0] w_half;
    logic [7:0]  w_byte;

    always_comb begin
        o_be    = '0;
        o_rdata = '0;
        o_fault = 1'b0;
        w_src   = i_wd;
        w_half  = i_addr_lo[1] ? i_old[31:16] : i_old[15:0];
        w_byte  = i_old[{i_addr_lo, 3'b000} +: 8];

        case (dm_op_e'(i_dm_op))
            DM_W: begin
                o_be    = 4'hF;
                o_fault = (i_addr_lo != 2'b00);
                o_rdata = i_old;
            end
            DM_H: begin
                o_be    = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                o_fault = i_addr_lo[0];
                // Replicate so either half-lane pair sees wd[15:0].
                w_src   = {2{i_wd[15:0]}};
                o_rdata = {{16{w_half[15]}}, w_half};
            end
            DM_B: begin
                o_be    = 4'b0001 << i_addr_lo;
                w_src   = {4{i_wd[7:0]}};
                o_rdata = {{24{w_byte[7]}}, w_byte};
            end
            default: begin
                o_fault = 1'b1;
            end
        endcase

        o_wdata = i_old;
        for (int unsigned i = 0; i < 4; i++) begin
            if (o_be[i]) begin
                o_wdata[8*i +: 8] = w_src[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/dm.sv
// Data memory stage: word array with async clear, lane-merged stores,
// sign-extended loads, fault detection and the simulation write log.
module dm
    import dm_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = DM_DEPTH_WORDS,
    parameter int unsigned AW          = DM_AW
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    input  logic [31:0] addr,
    input  logic [31:0] wd,
    input  logic        mem_write,
    input  logic [1:0]  dm_op,
    output logic [31:0] rd,
    output logic        fault
);

    localparam logic [31:0] BYTES = 32'(DEPTH_WORDS * 4);

    logic [31:0]   r_mem [0:DEPTH_WORDS-1];

    logic [AW-1:0] w_idx;
    logic [31:0]   w_old;
    logic [3:0]    w_be;
    logic [31:0]   w_wdata;
    logic [31:0]   w_rdata;
    logic          w_align_fault;
    logic          w_range_fault;
    logic          w_commit;

    assign w_idx         = addr[AW+1:2];
    assign w_range_fault = (addr >= BYTES);
    // Out-of-range index is never used: rd and the store are both gated by fault.
    assign w_old         = w_range_fault ? '0 : r_mem[w_idx];

    dm_lane u_lane (
        .i_addr_lo (addr[1:0]),
        .i_dm_op   (dm_op),
        .i_wd      (wd),
        .i_old     (w_old),
        .o_be      (w_be),
        .o_wdata   (w_wdata),
        .o_rdata   (w_rdata),
        .o_fault   (w_align_fault)
    );

    assign fault    = w_align_fault | w_range_fault;
    assign rd       = fault ? '0 : w_rdata;
    assign w_commit = mem_write & ~fault & (w_be != '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH_WORDS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_commit) begin
            r_mem[w_idx] <= w_wdata;
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!reset && w_commit) begin
            $display("@%h: *%h <= %h", pc, {addr[31:2], 2'b00}, w_wdata);
        end
    end
`endif

endmodule

// File: tb/tb_dm.sv
// Directed bench for dm: byte-addressed reference memory checked every cycle,
// plus literal expectations from the worked store/load examples.
module tb_dm;
    import dm_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc;
    logic [31:0] addr;
    logic [31:0] wd;
    logic        mem_write;
    logic [1:0]  dm_op;
    logic [31:0] rd;
    logic        fault;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    byte unsigned mb [0:DM_BYTES-1];

    dm #(.DEPTH_WORDS(3072), .AW(12)) u_dut (
        .clk       (clk),
        .reset     (reset),
        .pc        (pc),
        .addr      (addr),
        .wd        (wd),
        .mem_write (mem_write),
        .dm_op     (dm_op),
        .rd        (rd),
        .fault     (fault)
    );

    always #5 clk = ~clk;

    function automatic int unsigned acc_size(input logic [1:0] op);
        return (op == 2'b00) ? 4 : (op == 2'b01) ? 2 : 1;
    endfunction

    function automatic bit m_fault(input logic [1:0] op, input logic [31:0] a);
        if (op == 2'b11) return 1'b1;
        if (a >= DM_BYTES) return 1'b1;
        return (a % acc_size(op)) != 0;
    endfunction

    function automatic logic [31:0] m_read(input logic [1:0] op, input logic [31:0] a);
        int unsigned n;
        longint v;
        if (m_fault(op, a)) return 32'h0;
        n = acc_size(op);
        v = 0;
        for (int k = int'(n) - 1; k >= 0; k--) v = v * 256 + mb[a + 32'(k)];
        if (n == 2 && v >= 32768) v = v - 65536;
        if (n == 1 && v >= 128) v = v - 256;
        return 32'(v);
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DM_BYTES; i++) mb[i] = 8'h00;
        end else if (mem_write && !m_fault(dm_op, addr)) begin
            for (int k = 0; k < int'(acc_size(dm_op)); k++)
                mb[addr + 32'(k)] = wd[8*k +: 8];
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            logic [31:0] erd;
            logic        ef;
            erd = m_read(dm_op, addr);
            ef  = m_fault(dm_op, addr);
            checks++;
            if (rd !== erd || fault !== ef) begin
                errors++;
                $display("FAIL model op=%0d addr=%h: rd=%h fault=%b, expected rd=%h fault=%b",
                         dm_op, addr, rd, fault, erd, ef);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] d, input logic [31:0] p);
        mem_write = we;
        dm_op     = op;
        addr      = a;
        wd        = d;
        pc        = p;
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic rd_chk(input string name, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] exp);
        drive(1'b0, op, a, 32'h0, 32'h0);
        #1;
        chk(name, rd, exp);
    endtask

    initial begin
        drive(1'b0, 2'b00, 32'h0, 32'h0, 32'h0);
        #0 reset = 1'b1;
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        chk_en = 1'b1;

        rd_chk("reset_word0", 2'b00, 32'h0000, 32'h0000_0000);
        rd_chk("reset_word4", 2'b00, 32'h0004, 32'h0000_0000);

        drive(1'b1, 2'b00, 32'h0004, 32'h1234_5678, 32'h0000_3000);
        step();
        rd_chk("lw_0004", 2'b00, 32'h0004, 32'h1234_5678);
        rd_chk("lw_0000", 2'b00, 32'h0000, 32'h0000_0000);

        drive(1'b1, 2'b01, 32'h0006, 32'hABCD_8001, 32'h0000_3004);
        step();
        rd_chk("sh_merge", 2'b00, 32'h0004, 32'h8001_5678);
        rd_chk("lh_0006", 2'b01, 32'h0006, 32'hFFFF_8001);
        rd_chk("lh_0004", 2'b01, 32'h0004, 32'h0000_5678);

        drive(1'b1, 2'b10, 32'h0005, 32'h0000_00F0, 32'h0000_3008);
        step();
        rd_chk("sb_merge", 2'b00, 32'h0004, 32'h8001_F078);
        rd_chk("lb_0005", 2'b10, 32'h0005, 32'hFFFF_FFF0);
        rd_chk("lb_0004", 2'b10, 32'h0004, 32'h0000_0078);
        rd_chk("lb_0007", 2'b10, 32'h0007, 32'hFFFF_FF80);

        drive(1'b1, 2'b00, 32'h0002, 32'hFFFF_FFFF, 32'h0000_300C);
        #1;
        chk("sw_misalign_fault", {31'b0, fault}, 32'h1);
        chk("sw_misalign_rd", rd, 32'h0);
        step();
        rd_chk("sw_misalign_nowrite", 2'b00, 32'h0000, 32'h0000_0000);

        drive(1'b1, 2'b01, 32'h0003, 32'hFFFF_FFFF, 32'h0000_3010);
        #1;
        chk("sh_misalign_fault", {31'b0, fault}, 32'h1);
        step();
        drive(1'b1, 2'b00, 32'h3000, 32'hFFFF_FFFF, 32'h0000_3014);
        #1;
        chk("sw_range_fault", {31'b0, fault}, 32'h1);
        chk("sw_range_rd", rd, 32'h0);
        step();
        drive(1'b0, 2'b11, 32'h0004, 32'h0, 32'h0);
        #1;
        chk("reserved_fault", {31'b0, fault}, 32'h1);
        chk("reserved_rd", rd, 32'h0);

        drive(1'b1, 2'b00, 32'h2FFC, 32'hCAFE_F00D, 32'h0000_3018);
        #1;
        chk("top_word_nofault", {31'b0, fault}, 32'h0);
        step();
        rd_chk("top_word_lw", 2'b00, 32'h2FFC, 32'hCAFE_F00D);
        rd_chk("top_byte_lb", 2'b10, 32'h2FFF, 32'hFFFF_FFCA);
        rd_chk("past_top_lb", 2'b10, 32'h3000, 32'h0);

        drive(1'b1, 2'b00, 32'h0008, 32'hDEAD_BEEF, 32'h0000_301C);
        #1;
        chk("rdw_before", rd, 32'h0);
        @(posedge clk);
        #1;
        chk("rdw_after", rd, 32'hDEAD_BEEF);
        #1;
        drive(1'b1, 2'b10, 32'h0008, 32'h0000_0011, 32'h0000_3020);
        #1;
        chk("b2b_pre_edge", rd, 32'hFFFF_FFEF);
        step();
        rd_chk("b2b_merge", 2'b00, 32'h0008, 32'hDEAD_BE11);

        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 2'b00, 32'(4 * i), 32'hA5A5_0000 + 32'(i), 32'h0000_3100 + 32'(4 * i));
            step();
        end
        rd_chk("fill_word1", 2'b00, 32'h0004, 32'hA5A5_0001);
        drive(1'b1, 2'b00, 32'h0004, 32'h7777_7777, 32'h0000_3200);
        #1 reset = 1'b1;
        #1;
        chk("async_reset_rd", rd, 32'h0);
        @(posedge clk);
        #2 reset = 1'b0;
        rd_chk("reset_blocks_store", 2'b00, 32'h0004, 32'h0);
        rd_chk("reset_word3", 2'b00, 32'h000C, 32'h0);

        step();
        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: bench exceeded time limit");
        $fatal(1);
    end

endmodule
